// File: rtl/frame_sequencer.sv
// frame_sequencer: frame-level controller that admits IMG_W*IMG_H pixels, counts filtered results and flags frame completion.
// Optional feature: define FRAME_SOF_SYNC_EN to add s_tuser_i start-of-frame alignment of the input stream.
module frame_sequencer #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int CW    = 10
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       start_i,
    input  logic       irq_clr_i,
    input  logic       s_tvalid_i,
    input  logic [7:0] s_tdata_i,
`ifdef FRAME_SOF_SYNC_EN
    input  logic       s_tuser_i,
`endif
    output logic       s_tready_o,
    input  logic       fifo_prog_full_i,
    output logic       pix_valid_o,
    output logic [7:0] pix_data_o,
    input  logic       dp_valid_i,
    output logic       out_line_last_o,
    output logic       out_frame_last_o,
    output logic       busy_o,
    output logic       irq_o,
    output logic       err_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] IN_COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] IN_ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] OUT_COL_LAST = CW'(IMG_W - 3);
    localparam logic [CW-1:0] OUT_ROW_LAST = CW'(IMG_H - 3);

    state_t        state;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] out_col;
    logic [CW-1:0] out_row;
    logic          out_done;
    logic          beat;
    logic          take;
    logic          sof_err;
    logic [CW-1:0] pix_col;
    logic [CW-1:0] pix_row;
    logic          in_last;
    logic          arm;
    logic          dp_bad;
    logic          dp_ok;
    logic          frame_last_beat;

    assign s_tready_o = (state == RUN) && !fifo_prog_full_i;
    assign beat       = s_tvalid_i && s_tready_o;
    assign arm        = (state == IDLE) && start_i;

`ifdef FRAME_SOF_SYNC_EN
    logic sof_seen;
    logic sof;
    // A start-of-frame beat always becomes pixel (0,0); earlier unmarked beats are swallowed.
    assign sof     = beat && s_tuser_i;
    assign take    = beat && (sof_seen || s_tuser_i);
    assign sof_err = sof && (col != '0 || row != '0);
    assign pix_col = sof ? '0 : col;
    assign pix_row = sof ? '0 : row;

    // Remember that the frame has been aligned to its start-of-frame marker
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            sof_seen <= 1'b0;
        else
            sof_seen <= arm ? 1'b0 : (sof_seen || sof);
    end
`else
    assign take    = beat;
    assign sof_err = 1'b0;
    assign pix_col = col;
    assign pix_row = row;
`endif

    assign in_last          = take && pix_col == IN_COL_LAST && pix_row == IN_ROW_LAST;
    assign dp_bad           = dp_valid_i && (state == IDLE || state == DONE || out_done);
    assign dp_ok            = dp_valid_i && !dp_bad;
    assign out_line_last_o  = dp_valid_i && out_col == OUT_COL_LAST;
    assign out_frame_last_o = out_line_last_o && out_row == OUT_ROW_LAST;
    assign frame_last_beat  = dp_ok && out_frame_last_o;

    // Frame control FSM with registered busy/irq flags
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state  <= RUN;
                    busy_o <= 1'b1;
                end
                RUN: if (in_last) state <= DRAIN;
                DRAIN: if (out_done || frame_last_beat) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    irq_o  <= 1'b1;
                end
                DONE: if (irq_clr_i) begin
                    state <= IDLE;
                    irq_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input raster position and the one-cycle registered pixel handoff
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            col         <= '0;
            row         <= '0;
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
        end else begin
            pix_valid_o <= take;
            if (take)
                pix_data_o <= s_tdata_i;
            if (arm) begin
                col <= '0;
                row <= '0;
            end else if (take) begin
                col <= (pix_col == IN_COL_LAST) ? '0 : pix_col + CW'(1);
                row <= (pix_col != IN_COL_LAST) ? pix_row : (pix_row == IN_ROW_LAST) ? '0 : pix_row + CW'(1);
            end
        end
    end

    // Output result position and the sticky frame-drained flag
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_col  <= '0;
            out_row  <= '0;
            out_done <= 1'b0;
        end else if (arm) begin
            out_col  <= '0;
            out_row  <= '0;
            out_done <= 1'b0;
        end else if (dp_ok) begin
            out_col  <= out_line_last_o ? '0 : out_col + CW'(1);
            out_row  <= out_frame_last_o ? '0 : out_line_last_o ? out_row + CW'(1) : out_row;
            out_done <= out_done || out_frame_last_o;
        end
    end

    // Sticky protocol error; a new error in the clearing cycle takes precedence
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            err_o <= 1'b0;
        else
            err_o <= (dp_bad || sof_err) ? 1'b1 : irq_clr_i ? 1'b0 : err_o;
    end
endmodule
